// File: rtl/flexpipe_pkg.sv
// rtl/flexpipe_pkg.sv - shared FlexPipe memory types, channel id type and arbiter defaults
package flexpipe_pkg;

    // Memory request/response payloads carried between requesters and DRAM.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mem_resp_t;

    // Upper bound on arbiter channel count; sizes the tag stored per request.
    localparam int N_CH_MAX = 16;
    typedef logic [$clog2(N_CH_MAX)-1:0] chan_id_t;

    // Default arbiter configuration.
    localparam int MEM_ARB_N_CH            = 4;
    localparam int MEM_ARB_MAX_OUTSTANDING = 8;
    localparam int MEM_ARB_STARVE_LIMIT    = 16;

    // Round-robin candidate among channels 1..n_ch-1: start at base, step k, wrap n_ch-1 -> 1.
    function automatic int rr_index(input int base, input int k, input int n_ch);
        return 1 + ((base - 1 + k) % (n_ch - 1));
    endfunction

endpackage

// File: rtl/flexpipe_tag_fifo.sv
// rtl/flexpipe_tag_fifo.sv - synchronous FIFO of channel ids for in-order response routing
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i           write push_data_i (ignored when full, even if popping)
//   push_data_i      channel id to enqueue
//   pop_i            drop the head entry (ignored when empty)
//   pop_data_o       head entry
//   full_o, empty_o  occupancy flags
//   count_o          occupancy, one bit wider than the pointers
module flexpipe_tag_fifo
    import flexpipe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  chan_id_t               push_data_i,
    input  logic                   pop_i,
    output chan_id_t               pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    chan_id_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/flexpipe_mem_arbiter_n.sv
// rtl/flexpipe_mem_arbiter_n.sv - N-channel DRAM arbiter: core priority with starvation guard, round-robin DMA, tag-routed responses
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_i / req_valid_i       per-channel request payload and valid
//   req_ready_o               one-hot grant, only when DRAM and tag FIFO can accept
//   resp_o / resp_valid_o     DRAM response broadcast, one-hot valid for owning channel
//   mem_master_*              single DRAM master port (in-order responses)
//   no_outstanding_active     no channel-0 request in flight
//   outstanding_count         total requests in flight
//   err_orphan_resp           sticky: response arrived with no tag outstanding
module flexpipe_mem_arbiter_n
    import flexpipe_pkg::*;
#(
    parameter int N_CH            = MEM_ARB_N_CH,
    parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING,
    parameter int STARVE_LIMIT    = MEM_ARB_STARVE_LIMIT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  mem_req_t                         req_i [N_CH],
    input  logic [N_CH-1:0]                  req_valid_i,
    output logic [N_CH-1:0]                  req_ready_o,
    output mem_resp_t                        resp_o,
    output logic [N_CH-1:0]                  resp_valid_o,
    output mem_req_t                         mem_master_req,
    output logic                             mem_master_valid,
    input  logic                             mem_master_ready,
    input  mem_resp_t                        mem_master_resp,
    input  logic                             mem_master_resp_valid,
    output logic                             no_outstanding_active,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count,
    output logic                             err_orphan_resp
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0] active_cnt_q, active_cnt_d;
    logic             orphan_q, orphan_d;

    logic [IDX_W-1:0] winner, cand;
    logic             found;
    logic             others_elig, mask0, issue, handshake;
    logic             fifo_full, fifo_empty, pop;
    chan_id_t         head;
    logic             act_inc, act_dec;

    // ---------------- arbitration ----------------
    assign others_elig = |req_valid_i[N_CH-1:1];
    // Core loses priority only once it has starved a waiting DMA channel for STARVE_LIMIT grants.
    assign mask0       = (starve_cnt_q == SC_W'(STARVE_LIMIT)) && others_elig;

    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        if (req_valid_i[0] && !mask0) begin
            winner = '0;
        end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
                cand = IDX_W'(rr_index(int'(rr_ptr_q), k, N_CH));
                if (!found && req_valid_i[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    assign issue            = (|req_valid_i) && !fifo_full;
    assign handshake        = issue && mem_master_ready;
    assign mem_master_valid = issue;
    assign mem_master_req   = req_i[winner];

    always_comb begin
        req_ready_o = '0;
        if (handshake) req_ready_o[winner] = 1'b1;
    end

    // ---------------- response routing ----------------
    assign pop          = mem_master_resp_valid && !fifo_empty;
    assign resp_o       = mem_master_resp;
    assign resp_valid_o = pop ? (N_CH'(1) << head) : '0;

    flexpipe_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (handshake),
        .push_data_i (chan_id_t'(winner)),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_count)
    );

    // ---------------- state update ----------------
    assign act_inc = handshake && (winner == '0);
    assign act_dec = pop && (head == '0);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        active_cnt_d = active_cnt_q;
        orphan_d     = orphan_q || (mem_master_resp_valid && fifo_empty);

        if (handshake && winner != '0) begin
            rr_ptr_d = (winner == IDX_W'(N_CH - 1)) ? IDX_W'(1) : winner + 1'b1;
        end

        if (!others_elig) begin
            starve_cnt_d = '0;
        end else if (handshake && winner != '0) begin
            starve_cnt_d = '0;
        end else if (act_inc && starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        case ({act_inc, act_dec})
            2'b10:   active_cnt_d = active_cnt_q + 1'b1;
            2'b01:   active_cnt_d = active_cnt_q - 1'b1;
            default: active_cnt_d = active_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= IDX_W'(1);
            starve_cnt_q <= '0;
            active_cnt_q <= '0;
            orphan_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            active_cnt_q <= active_cnt_d;
            orphan_q     <= orphan_d;
        end
    end

    assign no_outstanding_active = (active_cnt_q == '0);
    assign err_orphan_resp       = orphan_q;

endmodule

// File: tb/tb_flexpipe_mem_arbiter_n.sv
// tb/tb_flexpipe_mem_arbiter_n.sv - randomized self-checking bench for flexpipe_mem_arbiter_n
module tb_flexpipe_mem_arbiter_n;
    import flexpipe_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 8;
    localparam int LIM  = 16;

    logic            clk = 1'b0;
    logic            rst;
    mem_req_t        req [N];
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    mem_resp_t       resp;
    logic [N-1:0]    resp_valid;
    mem_req_t        mm_req;
    logic            mm_valid;
    logic            mm_ready;
    mem_resp_t       mm_resp;
    logic            mm_resp_valid;
    logic            no_out_act;
    logic [3:0]      out_cnt;
    logic            orphan;

    always #5 clk = ~clk;

    flexpipe_mem_arbiter_n #(
        .N_CH            (N),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_i                 (req),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .resp_o                (resp),
        .resp_valid_o          (resp_valid),
        .mem_master_req        (mm_req),
        .mem_master_valid      (mm_valid),
        .mem_master_ready      (mm_ready),
        .mem_master_resp       (mm_resp),
        .mem_master_resp_valid (mm_resp_valid),
        .no_outstanding_active (no_out_act),
        .outstanding_count     (out_cnt),
        .err_orphan_resp       (orphan)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: tags in flight as a plain queue, plus arbitration bookkeeping.
    int q[$];
    int rr_m;
    int starve_m;
    bit orphan_m;
    int grant_log[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = '0;
        mm_ready      = 1'b0;
        mm_resp_valid = 1'b0;
        mm_resp       = '0;
        for (int c = 0; c < N; c++) req[c] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        rr_m     = 1;
        starve_m = 0;
        orphan_m = 1'b0;
    endtask

    task automatic run_cycle(input int vmask, input int pv, input int pr, input int presp, input bit orphan_ok);
        bit            others, any, exp_valid, hs, pop, has0;
        int            win, pre_size;
        logic [N-1:0]  exp_ready, exp_rv;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            req_valid[c] = vmask[c] && ($urandom_range(99) < pv);
            req[c]       = {1'($urandom), 32'($urandom), 32'($urandom)};
        end
        mm_ready      = ($urandom_range(99) < pr);
        mm_resp_valid = (q.size() > 0 || orphan_ok) && ($urandom_range(99) < presp);
        mm_resp       = 32'($urandom);
        #1;

        others    = |req_valid[N-1:1];
        any       = |req_valid;
        pre_size  = q.size();
        exp_valid = any && (pre_size < MAXO);
        win = 0;
        if (!(req_valid[0] && !(starve_m == LIM && others))) begin
            for (int k = N - 2; k >= 0; k--) begin
                int c;
                c = 1 + ((rr_m - 1 + k) % (N - 1));
                if (req_valid[c]) win = c;
            end
        end
        hs        = exp_valid && mm_ready;
        exp_ready = hs ? (N'(1) << win) : '0;
        pop       = mm_resp_valid && (pre_size > 0);
        exp_rv    = pop ? (N'(1) << q[0]) : '0;
        has0 = 1'b0;
        foreach (q[i]) if (q[i] == 0) has0 = 1'b1;

        check_eq("mem_master_valid", mm_valid, exp_valid);
        check_eq("req_ready_o", req_ready, exp_ready);
        if (exp_valid) check_eq("mem_master_req", mm_req, req[win]);
        check_eq("resp_valid_o", resp_valid, exp_rv);
        if (pop) check_eq("resp_o", resp, mm_resp);
        check_eq("no_outstanding_active", no_out_act, !has0);
        check_eq("outstanding_count", out_cnt, pre_size);
        check_eq("err_orphan_resp", orphan, orphan_m);

        if (hs) begin
            for (int c = 0; c < N; c++) if (req_ready[c]) grant_log.push_back(c);
        end

        if (mm_resp_valid && pre_size == 0) orphan_m = 1'b1;
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(win);
            if (win != 0) rr_m = (win == N - 1) ? 1 : win + 1;
        end
        if (!others)                        starve_m = 0;
        else if (hs && win != 0)            starve_m = 0;
        else if (hs && win == 0 && starve_m < LIM) starve_m++;
    endtask

    task automatic run_phase(input int cycles, input int vmask, input int pv, input int pr,
                             input int presp, input bit orphan_ok);
        for (int i = 0; i < cycles; i++) run_cycle(vmask, pv, pr, presp, orphan_ok);
    endtask

    initial begin
        int ch2_grants;
        do_reset();

        // Idle after reset.
        run_phase(5, 0, 0, 0, 0, 1'b0);

        // DMA channels only, no responses: round-robin order, then FIFO full.
        grant_log.delete();
        run_phase(12, 4'b1110, 100, 100, 0, 1'b0);
        check_eq("rr_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 6; i++) check_eq($sformatf("rr_order_%0d", i), grant_log[i], (i % 3) + 1);
        check_eq("full_count", out_cnt, 8);

        // Responses resume traffic.
        run_phase(12, 4'b1110, 100, 100, 100, 1'b0);

        // Core and channel 2 both saturating: starvation guard gives ch2 one slot per 17.
        grant_log.delete();
        run_phase(60, 4'b0101, 100, 100, 100, 1'b0);
        ch2_grants = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2) ch2_grants++;
        check_eq("starve_ch2_grants", ch2_grants, 3);
        check_eq("starve_first_ch2", grant_log[16], 2);

        // Core only, then drain.
        run_phase(20, 4'b0001, 100, 100, 50, 1'b0);
        run_phase(20, 0, 0, 0, 100, 1'b0);

        // Mixed random traffic, then drain.
        run_phase(400, 4'b1111, 60, 70, 50, 1'b0);
        run_phase(30, 0, 0, 0, 100, 1'b0);

        // Orphan responses on an empty FIFO; flag must stick.
        run_phase(3, 0, 0, 0, 100, 1'b1);
        run_phase(5, 0, 0, 0, 0, 1'b0);
        check_eq("orphan_sticky", orphan, 1'b1);

        // Reset clears everything.
        do_reset();
        #1;
        check_eq("post_reset_orphan", orphan, 1'b0);
        check_eq("post_reset_count", out_cnt, 0);
        check_eq("post_reset_no_out", no_out_act, 1'b1);
        run_phase(3, 0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flexpipe_mem_arbiter_n.md
# flexpipe_mem_arbiter_n

Parametrised N-channel memory arbiter between FlexPipe requesters and the single DRAM master port. Channel 0 is the active-core port and has strict priority, bounded by a starvation guard. Channels 1..N_CH-1 are prefetch/DMA ports served round-robin. In-order DRAM responses are routed back by a tag FIFO, and the block reports whether core (channel 0) traffic is still outstanding; the config manager uses this as its flip-safety term.

## Interface
- N_CH, 4: channel count, ≥2; channel 0 = active core
- MAX_OUTSTANDING, 8: tag FIFO depth, power of two
- STARVE_LIMIT, 16: consecutive channel-0 grants allowed while another channel waits; ≥1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_i  in  N_CH×mem_req_t  per-channel request payload
- req_valid_i  in  N_CH  per-channel request valid
- req_ready_o  out  N_CH  per-channel request accepted
- resp_o  out  mem_resp_t  response payload, broadcast to all channels
- resp_valid_o  out  N_CH  one-hot response valid for the owning channel
- mem_master_req  out  mem_req_t  DRAM request
- mem_master_valid  out  1  DRAM request valid
- mem_master_ready  in  1  DRAM accepts
- mem_master_resp  in  mem_resp_t  DRAM response, returned in request order
- mem_master_resp_valid  in  1  DRAM response valid
- no_outstanding_active  out  1  no channel-0 request in flight
- outstanding_count  out  $clog2(MAX_OUTSTANDING)+1  total requests in flight
- err_orphan_resp  out  1  sticky flag: response arrived with an empty tag FIFO

## Operation
- Eligible channel: req_valid_i high.
- Issue condition: some channel eligible and tag FIFO not full.
- Arbitration (combinational, one winner):
  - Channel 0 wins if eligible and not masked.
  - Channel 0 is masked when starve_cnt == STARVE_LIMIT and some channel 1..N-1 is eligible.
  - Otherwise the winner is the first eligible channel in 1..N-1, searching from rr_ptr with wrap.
- mem_master_valid = issue condition; mem_master_req = req_i[winner].
- req_ready_o[winner] = mem_master_ready && FIFO not full; all other bits 0.
- Handshake = mem_master_valid && mem_master_ready. On a handshake:
  - push winner index to the tag FIFO;
  - if winner ≠ 0, set rr_ptr = winner+1, wrapping N_CH-1 → 1.
- starve_cnt, saturating at STARVE_LIMIT:
  - +1 on a channel-0 handshake while any channel 1..N-1 is eligible;
  - cleared on a handshake of any channel ≠ 0;
  - cleared on any cycle where no channel 1..N-1 is eligible.
- Response path:
  - when mem_master_resp_valid is high and the FIFO is not empty: resp_valid_o = onehot(FIFO head), resp_o = mem_master_resp, pop the head;
  - when mem_master_resp_valid is high and the FIFO is empty: drop the response, set err_orphan_resp (cleared only by rst).
  - Channels cannot backpressure responses.
- active_cnt tracks channel-0 requests in flight: +1 on channel-0 push, −1 on channel-0 pop, net 0 when both occur in one cycle. no_outstanding_active = (active_cnt == 0).
- outstanding_count = FIFO occupancy.

## Timing
- Request path is combinational: a grant occurs in the same cycle as the valid. No added request latency.
- Response routing is combinational: resp_valid_o is asserted in the same cycle as mem_master_resp_valid.
- Push and pop in the same cycle are legal, including when the FIFO is full. A full FIFO never accepts a push, even with a simultaneous pop; this is the conservative choice for timing.
- Pointers and counts wrap mod MAX_OUTSTANDING; occupancy width is one bit wider than the pointer.
- Reset values: FIFO empty, rr_ptr=1, starve_cnt=0, active_cnt=0, err_orphan_resp=0. Outputs after reset: mem_master_valid=0, req_ready_o=0, resp_valid_o=0, no_outstanding_active=1, outstanding_count=0.
- Reset mid-transfer discards all tags. Any late DRAM response that follows sets err_orphan_resp; the system must reset the DRAM model alongside this block.
- The payload on req_i must stay stable while valid until the handshake. The arbiter may move the grant away from a channel before it is accepted, since it re-arbitrates every cycle.

## Structure
- flexpipe_pkg gains: mem_req_t/mem_resp_t (already present), chan_id_t sized $clog2(N_CH_MAX), and the default constants MEM_ARB_N_CH, MEM_ARB_MAX_OUTSTANDING, MEM_ARB_STARVE_LIMIT.
- One sub-module, flexpipe_tag_fifo: a synchronous FIFO of chan_id_t that outputs full, empty and count.
- The arbiter and counters live in the top of this block. flexpipe_top instantiates this block with N_CH=2 as a drop-in for the current two-port arbiter.

## Test plan
- Reset, then idle: no_outstanding_active=1, outstanding_count=0, all valid/ready outputs 0.
- Channels 1–3 held valid, mem_master_ready=1, channel 0 idle → grant order 1,2,3,1,2,3. After 6 in-order responses, resp_valid_o sequence = 0010,0100,1000,0010,0100,1000.
- Channel 0 and channel 2 valid continuously, STARVE_LIMIT=16 → 16 channel-0 grants, 1 channel-2 grant, repeating. starve_cnt never exceeds 16.
- Issue 8 requests with no responses → FIFO full: mem_master_valid=0, outstanding_count=8. One response → count=7 and issue resumes the next cycle.
- Channel-0 request accepted → no_outstanding_active drops the next cycle. A channel-0 push and pop in the same cycle leave active_cnt unchanged. no_outstanding_active returns to 1 after the last channel-0 response.
- mem_master_resp_valid pulsed with an empty FIFO → no resp_valid_o bit set, err_orphan_resp=1 and held until rst.
